seq_alu: RTL and testbench



---
 rtl/seq_alu_pkg.sv | 23 ++
 rtl/seq_alu_iter.sv | 110 +++++++++++
 rtl/seq_alu.sv | 174 +++++++++++++++++
 tb/tb_seq_alu.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcode, state and width definitions for the sequential ALU.
// No logic; constants only.
// Optional divider build selected by SEQ_ALU_DIV_EN.
package seq_alu_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_ADD = 3'd0;
  localparam logic [OPW-1:0] OP_SUB = 3'd1;
  localparam logic [OPW-1:0] OP_AND = 3'd2;
  localparam logic [OPW-1:0] OP_OR  = 3'd3;
  localparam logic [OPW-1:0] OP_XOR = 3'd4;
  localparam logic [OPW-1:0] OP_CMP = 3'd5;
  localparam logic [OPW-1:0] OP_MUL = 3'd6;
  localparam logic [OPW-1:0] OP_DIV = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY     = 2'd1,
    ST_DIV_BUSY = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_iter.sv
// Shared iterative datapath: shift-add multiply or restoring divide (SEQ_ALU_DIV_EN).
// Latency: WIDTH steps after start; last flags the final step, res_nxt is its value.
// No backpressure: once started it steps every cycle until the counter empties.
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               div_mode,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               last,
  output logic [2*WIDTH-1:0] res_nxt
);

  localparam int RW = 2 * WIDTH;

  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]    mul_nxt, step_nxt, acc_init, mcand_init;
  logic             shift_en;

  // One shift-add step: accumulate the multiplicand when the multiplier LSB is set
  always_comb begin
    mul_nxt = acc_q;
    if (mplier_q[0]) mul_nxt = acc_q + mcand_q;
  end

`ifdef SEQ_ALU_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   div_hi, div_diff;
  logic [RW-1:0]    div_nxt;

  // One restoring step on {remainder, dividend}; divisor lives in mcand low half
  always_comb begin
    div_hi   = acc_q[RW-1:WIDTH-1];
    div_diff = div_hi - {1'b0, mcand_q[WIDTH-1:0]};
    if (div_diff[WIDTH]) div_nxt = {div_hi[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else                 div_nxt = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  // Remember which operation was started
  always_comb begin
    div_d = div_q;
    if (start) div_d = div_mode;
  end

  // Mode register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) div_q <= 1'b0;
    else       div_q <= div_d;
  end

  assign step_nxt   = div_q ? div_nxt : mul_nxt;
  assign shift_en   = !div_q;
  assign acc_init   = div_mode ? RW'(op_a) : '0;
  assign mcand_init = div_mode ? RW'(op_b) : RW'(op_a);
`else
  logic unused_div;
  assign unused_div = div_mode;
  assign step_nxt   = mul_nxt;
  assign shift_en   = 1'b1;
  assign acc_init   = '0;
  assign mcand_init = RW'(op_a);
`endif

  // Load on start, otherwise step while the counter is non-zero
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      acc_d    = acc_init;
      mcand_d  = mcand_init;
      mplier_d = op_b;
      cnt_d    = CNTW'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_d    = step_nxt;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNTW'(1);
      if (shift_en) mcand_d = mcand_q << 1;
    end
  end

  // Datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign last    = (cnt_q == CNTW'(1));
  assign res_nxt = step_nxt;

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/arith, iterative MUL (and DIV when SEQ_ALU_DIV_EN).
// Latency: result registered on the accept edge for single-cycle ops; WIDTH edges for MUL/DIV.
// Backpressure: result and flags held while out_valid && !out_ready; in_ready low meanwhile.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPW-1:0]     opcode,
  input  logic [WIDTH-1:0]   number1,
  input  logic [WIDTH-1:0]   number2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] conclusion,
  output logic               balance_bit,
  output logic               equality_bit,
  output logic               error_bit
);

  localparam int RW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [RW-1:0]    conclusion_q, conclusion_d;
  logic             balance_q, balance_d;
  logic             equality_q, equality_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;

  logic             accept;
  logic [WIDTH:0]   sum_w, diff_w;
  logic             iter_start, iter_div, iter_last;
  logic [RW-1:0]    iter_res;

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign sum_w    = {1'b0, number1} + {1'b0, number2};
  assign diff_w   = {1'b0, number1} - {1'b0, number2};

  // Next state, single-cycle results and iterative-op completion
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    conclusion_d = conclusion_q;
    balance_d    = balance_q;
    equality_d   = equality_q;
    error_d      = error_q;
    a_d          = a_q;
    b_d          = b_q;
    iter_start   = 1'b0;
    iter_div     = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d          = number1;
          b_d          = number2;
          balance_d    = number1 > number2;
          equality_d   = number1 == number2;
          error_d      = 1'b0;
          conclusion_d = '0;
          out_valid_d  = 1'b1;
          case (opcode)
            OP_ADD: conclusion_d = RW'(sum_w);
            OP_SUB: conclusion_d = RW'(diff_w);
            OP_AND: conclusion_d = RW'(number1 & number2);
            OP_OR:  conclusion_d = RW'(number1 | number2);
            OP_XOR: conclusion_d = RW'(number1 ^ number2);
            OP_CMP: conclusion_d = '0;
            OP_MUL: begin
              // flags and result are published together at completion
              balance_d    = balance_q;
              equality_d   = equality_q;
              error_d      = error_q;
              conclusion_d = conclusion_q;
              out_valid_d  = 1'b0;
              iter_start   = 1'b1;
              state_d      = ST_BUSY;
            end
`ifdef SEQ_ALU_DIV_EN
            OP_DIV: begin
              if (number2 == '0) begin
                conclusion_d = {number1, {WIDTH{1'b1}}};
                error_d      = 1'b1;
              end else begin
                balance_d    = balance_q;
                equality_d   = equality_q;
                error_d      = error_q;
                conclusion_d = conclusion_q;
                out_valid_d  = 1'b0;
                iter_start   = 1'b1;
                iter_div     = 1'b1;
                state_d      = ST_DIV_BUSY;
              end
            end
`else
            OP_DIV: begin
              conclusion_d = '0;
              error_d      = 1'b1;
            end
`endif
            default: conclusion_d = '0;
          endcase
        end
      end
`ifdef SEQ_ALU_DIV_EN
      ST_BUSY, ST_DIV_BUSY: begin
`else
      ST_BUSY: begin
`endif
        if (iter_last) begin
          conclusion_d = iter_res;
          balance_d    = a_q > b_q;
          equality_d   = a_q == b_q;
          error_d      = 1'b0;
          out_valid_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers; reset aborts any operation in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      conclusion_q <= '0;
      balance_q    <= 1'b0;
      equality_q   <= 1'b0;
      error_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      conclusion_q <= conclusion_d;
      balance_q    <= balance_d;
      equality_q   <= equality_d;
      error_q      <= error_d;
      a_q          <= a_d;
      b_q          <= b_d;
    end
  end

  seq_alu_iter #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_iter (
    .clock    (clock),
    .reset    (reset),
    .start    (iter_start),
    .div_mode (iter_div),
    .op_a     (number1),
    .op_b     (number2),
    .last     (iter_last),
    .res_nxt  (iter_res)
  );

  assign out_valid    = out_valid_q;
  assign conclusion   = conclusion_q;
  assign balance_bit  = balance_q;
  assign equality_bit = equality_q;
  assign error_bit    = error_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8) with a result scoreboard.
// Latency measured as rising edges between the accept edge and first sight of out_valid.
// Covers hold under backpressure, async abort, and the SEQ_ALU_DIV_EN build when defined.
module tb_seq_alu;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  opcode;
  logic [7:0]  number1;
  logic [7:0]  number2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] conclusion;
  logic        balance_bit;
  logic        equality_bit;
  logic        error_bit;

  typedef struct packed {
    logic [15:0] res;
    logic        bal;
    logic        eq;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  seq_alu #(.WIDTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .number1      (number1),
    .number2      (number2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .conclusion   (conclusion),
    .balance_bit  (balance_bit),
    .equality_bit (equality_bit),
    .error_bit    (error_bit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [7:0] lo;
    e.bal = a > b;
    e.eq  = a == b;
    e.err = 1'b0;
    e.res = 16'h0000;
    case (op)
      3'd0: e.res = {8'h00, a} + {8'h00, b};
      3'd1: begin lo = a - b; e.res = {7'h00, (a < b), lo}; end
      3'd2: e.res = {8'h00, a & b};
      3'd3: e.res = {8'h00, a | b};
      3'd4: e.res = {8'h00, a ^ b};
      3'd5: e.res = 16'h0000;
      3'd6: e.res = {8'h00, a} * {8'h00, b};
      default: begin
`ifdef SEQ_ALU_DIV_EN
        if (b == 8'h00) begin
          e.res = {a, 8'hFF};
          e.err = 1'b1;
        end else begin
          e.res = {a % b, a / b};
        end
`else
        e.res = 16'h0000;
        e.err = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present an op, wait for in_ready, pass the accept edge.
  task automatic present(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int waited);
    in_valid = 1'b1;
    opcode   = op;
    number1  = a;
    number2  = b;
    waited   = 0;
    #1;
    while (!in_ready && waited < 50) begin
      @(posedge clock);
      #1;
      waited++;
    end
    if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    sb.push_back(model(op, a, b));
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int w;
    @(negedge clock);
    present(op, a, b, w);
  endtask

  // Wait for the result, check latency and busy span, compare against the scoreboard.
  task automatic expect_result(input string tag, input int exp_edges, input int exp_busy);
    int   n;
    int   busy;
    exp_t e;
    n    = 0;
    busy = 0;
    @(negedge clock);
    while (!out_valid && n < 100) begin
      if (!in_ready) busy++;
      @(negedge clock);
      n++;
    end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_edges"}, cyc - acc_cyc, exp_edges);
    chk({tag, "_busy"}, busy, exp_busy);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_res"}, {16'd0, conclusion}, {16'd0, e.res});
      chk({tag, "_bal"}, {31'd0, balance_bit}, {31'd0, e.bal});
      chk({tag, "_eq"}, {31'd0, equality_bit}, {31'd0, e.eq});
      chk({tag, "_err"}, {31'd0, error_bit}, {31'd0, e.err});
    end
  endtask

  initial begin
    int w;
    int seen;
    logic [2:0] rop;
    logic [7:0] ra, rb;

    reset     = 1'b1;
    in_valid  = 1'b0;
    opcode    = 3'd0;
    number1   = 8'h00;
    number2   = 8'h00;
    out_ready = 1'b1;

    // reset state
    @(negedge clock);
    @(negedge clock);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_conclusion", {16'd0, conclusion}, 32'd0);
    chk("rst_flags", {29'd0, balance_bit, equality_bit, error_bit}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // single-cycle ops
    drive(3'd0, 8'd200, 8'd100);
    chk("add_value", {16'd0, conclusion}, 32'h012C);
    expect_result("add", 0, 0);
    drive(3'd1, 8'd5, 8'd9);
    expect_result("sub", 0, 0);
    chk("sub_value", {16'd0, conclusion}, 32'h01FC);
    drive(3'd5, 8'd42, 8'd42);
    expect_result("cmp", 0, 0);
    chk("cmp_eq", {31'd0, equality_bit}, 32'd1);

    // multiply
    drive(3'd6, 8'd255, 8'd255);
    expect_result("mul", 8, 8);
    chk("mul_value", {16'd0, conclusion}, 32'h0000FE01);

    // backpressure hold, then consume and accept on the same edge
    @(negedge clock);
    out_ready = 1'b0;
    present(3'd0, 8'd1, 8'd1, w);
    expect_result("bp_add", 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_hold_res", {16'd0, conclusion}, 32'h0002);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clock);
    out_ready = 1'b1;
    present(3'd4, 8'hF0, 8'h0F, w);
    chk("bp_xor_wait", w, 0);
    expect_result("bp_xor", 0, 0);
    chk("bp_xor_value", {16'd0, conclusion}, 32'h00FF);

    // asynchronous reset in the middle of a multiply
    drive(3'd6, 8'h12, 8'h34);
    @(negedge clock);
    @(negedge clock);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_res", {16'd0, conclusion}, 32'd0);
    void'(sb.pop_back());
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    drive(3'd2, 8'hCC, 8'hAA);
    expect_result("and", 0, 0);
    chk("and_value", {16'd0, conclusion}, 32'h0088);

    // opcode 7
`ifdef SEQ_ALU_DIV_EN
    drive(3'd7, 8'd200, 8'd7);
    expect_result("div", 8, 8);
    chk("div_value", {16'd0, conclusion}, 32'h041C);
    drive(3'd7, 8'd9, 8'd0);
    expect_result("div0", 0, 0);
    chk("div0_value", {16'd0, conclusion}, 32'h09FF);
    chk("div0_err", {31'd0, error_bit}, 32'd1);
`else
    drive(3'd7, 8'd200, 8'd7);
    expect_result("op7", 0, 0);
    chk("op7_err", {31'd0, error_bit}, 32'd1);
`endif

    // mixed operations against the model
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 6));
      ra  = 8'($urandom_range(0, 255));
      rb  = (i == 3) ? ra : 8'($urandom_range(0, 255));
      drive(rop, ra, rb);
      expect_result("mix", (rop == 3'd6) ? 8 : 0, (rop == 3'd6) ? 8 : 0);
    end

    @(negedge clock);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
